// File: rtl/adder_seq_pkg.sv
// Shared definitions for the serial-nibble adder with two-requester arbitration.
//   state_t         : controller states (IDLE, RUN, DONE)
//   NIBBLES_DEFAULT : default number of 4-bit digits per operand
package adder_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned NIBBLES_DEFAULT = 4;

endpackage : adder_seq_pkg

// File: rtl/nibble_adder.sv
// Combinational 4-bit adder with carry in/out; the single arithmetic unit
// shared by both requesters.
//   a_i, b_i  : 4-bit addends
//   cin_i     : carry in
//   sum_o     : 4-bit sum
//   cout_o    : carry out of bit 3
module nibble_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [4:0] total;

    always_comb begin
        total  = 5'(a_i) + 5'(b_i) + 5'(cin_i);
        sum_o  = total[3:0];
        cout_o = total[4];
    end

endmodule : nibble_adder

// File: rtl/adder_seq_arb.sv
// Two-requester sequential adder. One 4-bit adder is time-shared: after a
// handshake the operands are summed one nibble per cycle, LSB first, and the
// result is presented on a valid/ready response port.
//   clk, rst_n            : clock, asynchronous active-low reset
//   reqN_valid/reqN_ready : request handshake for requester N (N = 0, 1)
//   reqN_a, reqN_b        : W-bit operands, W = 4*NIBBLES
//   reqN_cin              : carry in
//   rsp_valid/rsp_ready   : response handshake
//   rsp_id                : index of the requester that owns the result
//   rsp_sum, rsp_cout     : A + B + cin modulo 2^W, and carry out of bit W-1
module adder_seq_arb
    import adder_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = NIBBLES_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*NIBBLES-1:0] req0_a,
    input  logic [4*NIBBLES-1:0] req0_b,
    input  logic                 req0_cin,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*NIBBLES-1:0] req1_a,
    input  logic [4*NIBBLES-1:0] req1_b,
    input  logic                 req1_cin,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [4*NIBBLES-1:0] rsp_sum,
    output logic                 rsp_cout
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    state_t          state_q;
    logic [W-1:0]    a_q, b_q;      // operands, shifted right one nibble per RUN cycle
    logic [W-1:0]    acc_q;         // partial sum, filled from the top down
    logic            carry_q;
    logic [CW-1:0]   cnt_q;
    logic            id_q;          // requester being served
    logic            prio_q;        // requester preferred on a tie (0 after reset)
    logic [W-1:0]    sum_q;         // published result, held outside DONE
    logic            cout_q;
    logic            rid_q;

    logic            gnt0, gnt1, idle;
    logic [3:0]      nib_sum;
    logic            nib_cout;
    logic [W-1:0]    acc_d;

    // Tie goes to the requester that was not served last; prio_q stores that
    // preferred index directly so that its reset value of 0 favours requester 0.
    always_comb begin
        idle       = (state_q == IDLE);
        gnt0       = req0_valid & (~req1_valid | ~prio_q);
        gnt1       = req1_valid & (~req0_valid |  prio_q);
        req0_ready = rst_n & idle & gnt0;
        req1_ready = rst_n & idle & gnt1;
    end

    nibble_adder u_nibble_adder (
        .a_i    (a_q[3:0]),
        .b_i    (b_q[3:0]),
        .cin_i  (carry_q),
        .sum_o  (nib_sum),
        .cout_o (nib_cout)
    );

    // Operands shift down so the adder always sees bit 0..3; each sum nibble
    // enters at the top of the accumulator, so after NIBBLES cycles nibble k
    // sits at position k.
    always_comb begin
        acc_d = (acc_q >> 4) | (W'(nib_sum) << (W - 4));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            id_q    <= 1'b0;
            prio_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            rid_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt0 | gnt1) begin
                        a_q     <= gnt1 ? req1_a   : req0_a;
                        b_q     <= gnt1 ? req1_b   : req0_b;
                        carry_q <= gnt1 ? req1_cin : req0_cin;
                        id_q    <= gnt1;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> 4;
                    b_q     <= b_q >> 4;
                    acc_q   <= acc_d;
                    carry_q <= nib_cout;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= acc_d;
                        cout_q  <= nib_cout;
                        rid_q   <= id_q;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        prio_q  <= ~rid_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        rsp_valid = (state_q == DONE);
        rsp_id    = rid_q;
        rsp_sum   = sum_q;
        rsp_cout  = cout_q;
    end

endmodule : adder_seq_arb

// File: tb/tb_adder_seq_arb.sv
// Directed bench for adder_seq_arb with NIBBLES = 4.
module tb_adder_seq_arb;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk, rst_n;
    logic         req0_valid, req0_ready, req0_cin;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_cin;
    logic [W-1:0] req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_cout;
    logic [W-1:0] rsp_sum;

    int errors = 0;
    int checks = 0;

    adder_seq_arb #(.NIBBLES(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_cin   (req0_cin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_cin   (req1_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_sum    (rsp_sum),
        .rsp_cout   (rsp_cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int r, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
        if (r == 0) begin
            req0_valid = v; req0_a = a; req0_b = b; req0_cin = c;
        end else begin
            req1_valid = v; req1_a = a; req1_b = b; req1_cin = c;
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_sum"},   32'(rsp_sum),   32'd0);
        chk({tag, "_rsp_cout"},  32'(rsp_cout),  32'd0);
        chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
        chk({tag, "_rdy0"},      32'(req0_ready), 32'd0);
        chk({tag, "_rdy1"},      32'(req1_ready), 32'd0);
    endtask

    // Called just after a posedge handshake; returns at the first negedge
    // with rsp_valid high (n = negedges counted since the handshake).
    task automatic wait_rsp(output int n);
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (rsp_valid === 1'b1) break;
            chk("run_rdy0", 32'(req0_ready), 32'd0);
            chk("run_rdy1", 32'(req1_ready), 32'd0);
        end
        chk("rsp_timeout", 32'(rsp_valid), 32'd1);
    endtask

    // Starts at an IDLE negedge, returns at the DONE negedge.
    task automatic run_op(input int r, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic [W-1:0] exp_sum, input logic exp_cout);
        int n;
        drive(r, 1'b1, a, b, c);
        #1;
        chk("grant_rdy0", 32'(req0_ready), 32'(r == 0));
        chk("grant_rdy1", 32'(req1_ready), 32'(r == 1));
        @(posedge clk);
        #1;
        // operands change after the handshake and must be ignored
        drive(r, 1'b1, 16'hDEAD, 16'hBEEF, ~c);
        wait_rsp(n);
        chk("latency",  32'(n),        32'd5);
        chk("sum",      32'(rsp_sum),  32'(exp_sum));
        chk("cout",     32'(rsp_cout), 32'(exp_cout));
        chk("id",       32'(rsp_id),   32'(r));
        chk("done_rdy0", 32'(req0_ready), 32'd0);
        chk("done_rdy1", 32'(req1_ready), 32'd0);
        drive(r, 1'b0, '0, '0, 1'b0);
    endtask

    initial begin
        int n;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive(0, 1'b1, 16'h1234, 16'h4321, 1'b0);
        drive(1, 1'b1, 16'h1111, 16'h1111, 1'b1);
        repeat (2) @(negedge clk);
        chk_zero("reset");
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_rdy0", 32'(req0_ready), 32'd0);
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);

        // basic op and carry ripple
        run_op(0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        @(negedge clk);
        chk("after_accept_valid", 32'(rsp_valid), 32'd0);
        chk("hold_sum", 32'(rsp_sum), 32'h5555);
        run_op(1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1);
        @(negedge clk);
        run_op(1, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
        @(negedge clk);

        // tie arbitration from reset: 0,1,0,1
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 16'h0001, 16'h0002, 1'b0);
        drive(1, 1'b1, 16'h0010, 16'h0020, 1'b0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("tie_rdy0", 32'(req0_ready), 32'((k % 2) == 0));
            chk("tie_rdy1", 32'(req1_ready), 32'((k % 2) == 1));
            wait_rsp(n);
            chk("tie_lat", 32'(n), 32'd5);
            chk("tie_id",  32'(rsp_id), 32'(k % 2));
            chk("tie_sum", 32'(rsp_sum), ((k % 2) == 0) ? 32'h0003 : 32'h0030);
            @(negedge clk);
        end
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);

        // consumer backpressure
        rsp_ready = 1'b0;
        drive(0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
        #1;
        chk("bp_rdy0", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, '0, '0, 1'b0);
        drive(1, 1'b1, 16'h0F0F, 16'h0101, 1'b0);
        wait_rsp(n);
        chk("bp_lat", 32'(n), 32'd5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_sum",   32'(rsp_sum),   32'h0100);
            chk("bp_id",    32'(rsp_id),    32'd0);
            chk("bp_rdy0",  32'(req0_ready), 32'd0);
            chk("bp_rdy1",  32'(req1_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_accepted", 32'(rsp_valid), 32'd0);
        chk("bp_hold_sum", 32'(rsp_sum),   32'h0100);
        chk("bp_idle_rdy1", 32'(req1_ready), 32'd1);
        drive(1, 1'b0, '0, '0, 1'b0);
        #1;
        chk("bp_drop_rdy1", 32'(req1_ready), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_single", 32'(rsp_valid), 32'd0);
        end

        // reset in the middle of RUN with nibble 2 pending
        drive(0, 1'b1, 16'h1111, 16'h2222, 1'b1);
        #1;
        chk("ab_rdy0", 32'(req0_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(0, 1'b0, '0, '0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        drive(1, 1'b1, 16'h0001, 16'h0001, 1'b0);
        #1;
        chk_zero("abort");
        drive(1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        run_op(1, 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0);
        @(negedge clk);

        // next tie after serving requester 1 goes to requester 0
        drive(0, 1'b1, 16'h7FFF, 16'h0001, 1'b0);
        drive(1, 1'b1, 16'hAAAA, 16'h5555, 1'b1);
        #1;
        chk("post_tie_rdy0", 32'(req0_ready), 32'd1);
        chk("post_tie_rdy1", 32'(req1_ready), 32'd0);
        @(posedge clk);
        #1;
        drive(0, 1'b0, '0, '0, 1'b0);
        wait_rsp(n);
        chk("post_tie_id0",  32'(rsp_id),   32'd0);
        chk("post_tie_sum0", 32'(rsp_sum),  32'h8000);
        chk("post_tie_cout0", 32'(rsp_cout), 32'd0);
        @(negedge clk);
        chk("post_tie_rdy1b", 32'(req1_ready), 32'd1);
        @(posedge clk);
        #1;
        drive(1, 1'b0, '0, '0, 1'b0);
        wait_rsp(n);
        chk("post_tie_id1",  32'(rsp_id),   32'd1);
        chk("post_tie_sum1", 32'(rsp_sum),  32'h0000);
        chk("post_tie_cout1", 32'(rsp_cout), 32'd1);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_adder_seq_arb

// File: doc/adder_seq_arb.md
ADDER_SEQ_ARB -- requirements
Module: adder_seq_arb

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit digits per operand; operand width W = 4*NIBBLES; legal range 1..8.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_a, req0_b  input  W  requester 0 operands.
REQ-007 req0_cin  input  1  requester 0 carry-in.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_cin: same directions, widths and meaning, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result when high with rsp_valid.
REQ-011 rsp_id  output  1  requester index owning the result.
REQ-012 rsp_sum  output  W  A + B + cin, modulo 2^W.
REQ-013 rsp_cout  output  1  carry out of bit W-1.

Function
REQ-014 The block SHALL share one 4-bit adder between both requesters, computing one nibble per cycle, least significant first.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; reset state IDLE.
REQ-016 In IDLE, the block SHALL assert exactly one reqN_ready, for the granted requester only, combinationally from the valids; the other ready SHALL be low. With no valid, both readies SHALL be low.
REQ-017 Grant: a sole valid requester SHALL win; when both are valid, the requester not served last SHALL win; the last-served pointer SHALL reset so requester 0 wins the first tie.
REQ-018 On handshake the block SHALL capture a, b, cin and requester index, clear the nibble counter, and go to RUN.
REQ-019 In RUN, each cycle SHALL add nibble k of a and b with the carry register, store the sum nibble at position k, update the carry register, increment k; after nibble NIBBLES-1 the block SHALL go to DONE.
REQ-020 In RUN and DONE both readies SHALL be low; operands are sampled only at the handshake.
REQ-021 In DONE, rsp_valid SHALL be high, and rsp_id, rsp_sum and rsp_cout SHALL be stable until rsp_ready is high; then the block SHALL return to IDLE and update the last-served pointer.
REQ-022 Latency: handshake in cycle c SHALL give rsp_valid high from cycle c+NIBBLES+1; no new request SHALL be accepted in the DONE cycle, so minimum spacing is NIBBLES+2 cycles.
REQ-023 Carry SHALL ripple across nibble boundaries through the carry register; cout is the carry out of the final nibble.
REQ-024 A requester dropping valid before handshake SHALL have no effect; it is not granted.
REQ-025 Outside DONE, rsp_valid SHALL be low; rsp_sum, rsp_cout and rsp_id SHALL hold their last values.

Reset
REQ-026 Asserting rst_n low in any state, including mid-RUN, SHALL asynchronously force IDLE, abort the operation, and clear the result, carry, counter, id and pointer registers to 0.
REQ-027 While rst_n is low, all outputs SHALL be 0; the aborted operation SHALL never produce a response.

Structure
REQ-028 Shared package adder_seq_pkg SHALL hold the state enum and the NIBBLES default constant.
REQ-029 Sub-module nibble_adder (4-bit a, b, cin -> 4-bit sum, cout; combinational) SHALL be instanced exactly once.

Verification (NIBBLES=4)
REQ-030 Requester 0 sends a=0x1234, b=0x4321, cin=0 -> rsp_sum=0x5555, cout=0, id=0, rsp_valid exactly 5 cycles after the handshake.
REQ-031 Requester 1 sends a=0xFFFF, b=0x0000, cin=1 -> rsp_sum=0x0000, cout=1, id=1; a=0x8000, b=0x8000, cin=0 -> 0x0000, cout=1.
REQ-032 Both requesters valid continuously after reset -> grants 0,1,0,1, one response per operation with the matching id.
REQ-033 rsp_ready held low 3 cycles in DONE -> response stable, both readies low, then one response accepted.
REQ-034 rst_n low during RUN with nibble 2 pending -> no response; after release, req1 alone sends 0x0001+0x0001 -> 0x0002, id=1, and the next tie grants requester 0.
